// File: rtl/ifc_or_arbiter_pkg.sv
// Shared definitions for the ifc_or round-robin arbiter.
//   tag_width(n)   : width of a requester index (clog2(n), at least 1)
//   cnt_width(d)   : width of an occupancy counter able to hold 0..d
//   rr_pick(v,p,n) : first set bit of v[n-1:0] scanning p, p+1, ... mod n
package ifc_or_arb_pkg;

    localparam int unsigned MAX_N = 8;

    function automatic int unsigned tag_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Returns ptr when no bit is set; callers gate on "any set" themselves.
    function automatic int unsigned rr_pick(input logic [MAX_N-1:0] full_vec,
                                            input int unsigned      ptr,
                                            input int unsigned      n);
        int unsigned idx;
        int unsigned pick;
        logic        found;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < n; k++) begin
            idx = (ptr + k) % n;
            if (!found && full_vec[idx[2:0]]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/ifc_or_arbiter_tag_fifo.sv
// In-order tag FIFO recording which requester owns each in-flight result.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   push        : write push_data (ignored while full)
//   push_data   : requester index to record
//   pop         : drop the head entry (ignored while empty)
//   head        : oldest entry
//   empty, full : occupancy flags (count==0 / count==DEPTH)
module ifc_tag_fifo
    import ifc_or_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [TAG_W-1:0] push_data,
    input  logic             pop,
    output logic [TAG_W-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int unsigned CNT_W = cnt_width(DEPTH);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [TAG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifc_or_arbiter.sv
// Round-robin arbiter sharing one ifc_or instance between N requesters.
// Ports:
//   CLK, RST_N            : clock, synchronous active-low reset
//   req_en/req_a/req_b    : per-requester operand enqueue (slice i*W +: W)
//   req_rdy               : requester i's holding slot is empty
//   rsp_en/rsp_rdy        : per-requester result dequeue; rsp_rdy marks the head owner
//   rsp_data              : ifc_or result, broadcast to all requesters
//   or_a_*/or_b_*/or_y_*  : glue to the shared ifc_or enqueue/dequeue methods
module ifc_or_arbiter
    import ifc_or_arb_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned W     = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic [N-1:0]   req_en,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    output logic [N-1:0]   req_rdy,
    input  logic [N-1:0]   rsp_en,
    output logic [W-1:0]   rsp_data,
    output logic [N-1:0]   rsp_rdy,
    output logic           or_a_en,
    output logic [W-1:0]   or_a_data,
    input  logic           or_a_rdy,
    output logic           or_b_en,
    output logic [W-1:0]   or_b_data,
    input  logic           or_b_rdy,
    output logic           or_y_en,
    input  logic [W-1:0]   or_y_data,
    input  logic           or_y_rdy
);

    localparam int unsigned TAG_W = tag_width(N);

    logic [N-1:0]     full;
    logic [W-1:0]     a_reg [N];
    logic [W-1:0]     b_reg [N];
    logic [TAG_W-1:0] rr_ptr;
    logic [TAG_W-1:0] grant;
    logic [TAG_W-1:0] fifo_head;
    logic [MAX_N-1:0] full_pad;
    logic             fifo_empty;
    logic             fifo_full;
    logic             issue_ok;

    always_comb begin
        full_pad        = '0;
        full_pad[N-1:0] = full;
        grant           = TAG_W'(rr_pick(full_pad, 32'(rr_ptr), N));
    end

    // A full FIFO blocks issue even when a pop lands on the same edge.
    assign issue_ok = RST_N & or_a_rdy & or_b_rdy & ~fifo_full & (|full);

    assign or_a_en   = issue_ok;
    assign or_b_en   = issue_ok;
    assign or_a_data = issue_ok ? a_reg[grant] : '0;
    assign or_b_data = issue_ok ? b_reg[grant] : '0;

    assign req_rdy  = {N{RST_N}} & ~full;
    assign rsp_data = or_y_data;

    always_comb begin
        rsp_rdy = '0;
        if (RST_N && or_y_rdy && !fifo_empty) begin
            rsp_rdy[fifo_head] = 1'b1;
        end
    end

    assign or_y_en = |(rsp_en & rsp_rdy);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            full   <= '0;
            rr_ptr <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                // A granted slot is full, so it can never also be loaded here.
                if (issue_ok && grant == TAG_W'(i)) begin
                    full[i] <= 1'b0;
                end else if (req_en[i] && !full[i]) begin
                    full[i]  <= 1'b1;
                    a_reg[i] <= req_a[i*W +: W];
                    b_reg[i] <= req_b[i*W +: W];
                end
            end
            if (issue_ok) begin
                rr_ptr <= (grant == TAG_W'(N - 1)) ? '0 : grant + TAG_W'(1);
            end
        end
    end

    ifc_tag_fifo #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_tag_fifo (
        .clk       (CLK),
        .rst_n     (RST_N),
        .push      (issue_ok),
        .push_data (grant),
        .pop       (or_y_en),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_ifc_or_arbiter.sv
// Self-checking bench for ifc_or_arbiter: emulates the shared ifc_or as an
// in-order result queue and keeps a transaction-level model of the arbiter.
module tb_ifc_or_arbiter;

    localparam int N     = 4;
    localparam int W     = 1;
    localparam int DEPTH = 4;

    logic           CLK = 1'b0;
    logic           RST_N = 1'b0;
    logic [N-1:0]   req_en = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   req_rdy;
    logic [N-1:0]   rsp_en = '0;
    logic [W-1:0]   rsp_data;
    logic [N-1:0]   rsp_rdy;
    logic           or_a_en;
    logic [W-1:0]   or_a_data;
    logic           or_a_rdy = 1'b1;
    logic           or_b_en;
    logic [W-1:0]   or_b_data;
    logic           or_b_rdy = 1'b1;
    logic           or_y_en;
    logic [W-1:0]   or_y_data = '0;
    logic           or_y_rdy = 1'b0;

    ifc_or_arbiter #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_en(req_en), .req_a(req_a), .req_b(req_b), .req_rdy(req_rdy),
        .rsp_en(rsp_en), .rsp_data(rsp_data), .rsp_rdy(rsp_rdy),
        .or_a_en(or_a_en), .or_a_data(or_a_data), .or_a_rdy(or_a_rdy),
        .or_b_en(or_b_en), .or_b_data(or_b_data), .or_b_rdy(or_b_rdy),
        .or_y_en(or_y_en), .or_y_data(or_y_data), .or_y_rdy(or_y_rdy)
    );

    initial forever #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // bench controls
    logic         y_allow = 1'b0;
    logic [N-1:0] take_mask = '0;
    logic [N-1:0] rereq_mask = '0;
    int           cyc = 0;

    // model state
    logic [N-1:0] mfull = '0;
    logic [W-1:0] ma [N];
    logic [W-1:0] mb [N];
    int           mptr = 0;
    int           mtags[$];
    logic [W-1:0] mres[$];
    logic [W-1:0] orq[$];
    int           glog[$];
    int           take_log[$];

    // per-cycle expectations (computed at negedge, applied at posedge)
    logic [N-1:0] e_rdy = '0;
    logic [N-1:0] e_rsp = '0;
    logic         e_issue = 1'b0;
    logic         e_yen = 1'b0;
    int           e_grant = 0;
    int           best;
    logic         s_push = 1'b0;
    logic         s_pop = 1'b0;
    logic [W-1:0] s_y = '0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        e_rdy   = '0;
        e_rsp   = '0;
        e_issue = 1'b0;
        e_yen   = 1'b0;
        e_grant = 0;
        if (RST_N) begin
            e_rdy = ~mfull;
            if (or_a_rdy && or_b_rdy && mtags.size() < DEPTH && mfull != '0) begin
                e_issue = 1'b1;
                best    = N;
                // owner is the full slot at the smallest forward distance from the pointer
                for (int i = 0; i < N; i++) begin
                    if (mfull[i] && ((i - mptr + N) % N) < best) begin
                        best    = (i - mptr + N) % N;
                        e_grant = i;
                    end
                end
            end
            if (or_y_rdy && mtags.size() > 0) e_rsp[mtags[0]] = 1'b1;
            e_yen = (rsp_en & e_rsp) != '0;
        end
        chk("req_rdy", 32'(req_rdy), 32'(e_rdy));
        chk("or_a_en", 32'(or_a_en), 32'(e_issue));
        chk("or_b_en", 32'(or_b_en), 32'(e_issue));
        if (e_issue) begin
            chk("or_a_data", 32'(or_a_data), 32'(ma[e_grant]));
            chk("or_b_data", 32'(or_b_data), 32'(mb[e_grant]));
        end else if (!RST_N) begin
            chk("or_a_data_rst", 32'(or_a_data), 32'(0));
            chk("or_b_data_rst", 32'(or_b_data), 32'(0));
        end
        chk("rsp_rdy", 32'(rsp_rdy), 32'(e_rsp));
        chk("or_y_en", 32'(or_y_en), 32'(e_yen));
        if (e_rsp != '0) chk("rsp_data", 32'(rsp_data), 32'(mres[0]));
        total++;
        assert (!(RST_N && or_y_rdy && mtags.size() == 0)) else begin
            bad++;
            $display("FAIL y_rdy_empty: or_y_rdy=1 with no tag outstanding at t=%0t", $time);
        end
        s_push = or_a_en && or_b_en && or_a_rdy && or_b_rdy;
        s_y    = or_a_data | or_b_data;
        s_pop  = or_y_en && or_y_rdy;
    end

    always @(posedge CLK) begin
        if (!RST_N) begin
            mfull = '0;
            mptr  = 0;
            mtags.delete();
            mres.delete();
            orq.delete();
        end else begin
            if (s_pop && orq.size() > 0) void'(orq.pop_front());
            if (s_push) orq.push_back(s_y);
            if (e_yen) begin
                take_log.push_back(mtags[0]);
                void'(mtags.pop_front());
                void'(mres.pop_front());
            end
            if (e_issue) begin
                mfull[e_grant] = 1'b0;
                mtags.push_back(e_grant);
                mres.push_back(ma[e_grant] | mb[e_grant]);
                mptr = (e_grant + 1) % N;
                glog.push_back(e_grant);
            end
            for (int i = 0; i < N; i++) begin
                if (req_en[i] && e_rdy[i]) begin
                    mfull[i] = 1'b1;
                    ma[i]    = req_a[i*W +: W];
                    mb[i]    = req_b[i*W +: W];
                end
            end
        end
    end

    task automatic drive();
        logic [N-1:0] head_own;
        or_y_rdy  = RST_N && y_allow && (orq.size() > 0);
        or_y_data = (orq.size() > 0) ? orq[0] : '0;
        head_own  = '0;
        if (RST_N && or_y_rdy && mtags.size() > 0) head_own[mtags[0]] = 1'b1;
        rsp_en = take_mask & head_own;
        for (int i = 0; i < N; i++) begin
            if (RST_N && rereq_mask[i] && !mfull[i]) begin
                req_en[i]       = 1'b1;
                req_a[i*W +: W] = W'(cyc);
                req_b[i*W +: W] = W'(i == 3);
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        req_en = '0;
        rsp_en = '0;
        drive();
    endtask

    task automatic send(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_en[i]       = 1'b1;
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic do_reset();
        rereq_mask = '0;
        take_mask  = '0;
        y_allow    = 1'b0;
        or_a_rdy   = 1'b1;
        or_b_rdy   = 1'b1;
        RST_N      = 1'b0;
        req_en     = '0;
        rsp_en     = '0;
        drive();
        tick();
        tick();
        RST_N = 1'b1;
        drive();
    endtask

    int gbase;
    int tbase;

    initial begin
        // reset state
        do_reset();
        RST_N = 1'b0;
        drive();
        @(negedge CLK);
        chk("rst_req_rdy", 32'(req_rdy), 32'(0));
        chk("rst_or_a_en", 32'(or_a_en), 32'(0));
        tick();
        RST_N = 1'b1;
        drive();

        // all four requesters in one cycle
        gbase = glog.size();
        tbase = take_log.size();
        for (int i = 0; i < N; i++) send(i, W'(i == 1 || i == 3), W'(i == 2));
        repeat (6) tick();
        chk("all4_issue_cnt", 32'(glog.size() - gbase), 32'(4));
        for (int k = 0; k < 4; k++)
            if (gbase + k < glog.size()) chk("all4_grant", 32'(glog[gbase+k]), 32'(k));
        y_allow   = 1'b1;
        take_mask = '1;
        repeat (7) tick();
        chk("all4_take_cnt", 32'(take_log.size() - tbase), 32'(4));
        for (int k = 0; k < 4; k++)
            if (tbase + k < take_log.size()) chk("all4_take", 32'(take_log[tbase+k]), 32'(k));

        // reset with two operations in flight
        do_reset();
        send(0, 1'b1, 1'b1);
        send(1, 1'b0, 1'b0);
        repeat (3) tick();
        RST_N = 1'b0;
        drive();
        @(negedge CLK);
        chk("mid_rst_req_rdy", 32'(req_rdy), 32'(0));
        chk("mid_rst_rsp_rdy", 32'(rsp_rdy), 32'(0));
        chk("mid_rst_a_en", 32'(or_a_en), 32'(0));
        chk("mid_rst_y_en", 32'(or_y_en), 32'(0));
        tick();
        RST_N     = 1'b1;
        y_allow   = 1'b1;
        take_mask = '1;
        drive();
        gbase = glog.size();
        send(2, 1'b1, 1'b0);
        send(0, 1'b0, 1'b1);
        @(negedge CLK);
        chk("post_rst_rsp_rdy", 32'(rsp_rdy), 32'(0));
        chk("post_rst_req_rdy", 32'(req_rdy), 32'(4'b1111));
        repeat (5) tick();
        chk("post_rst_issues", 32'(glog.size() - gbase), 32'(2));
        if (glog.size() >= gbase + 2) begin
            chk("post_rst_g0", 32'(glog[gbase]), 32'(0));
            chk("post_rst_g1", 32'(glog[gbase+1]), 32'(2));
        end

        // single op
        do_reset();
        send(0, 1'b1, 1'b0);
        tick();
        @(negedge CLK);
        chk("single_a_en", 32'(or_a_en), 32'(1));
        chk("single_b_en", 32'(or_b_en), 32'(1));
        chk("single_a_data", 32'(or_a_data), 32'(1));
        chk("single_b_data", 32'(or_b_data), 32'(0));
        y_allow   = 1'b1;
        take_mask = 4'b0001;
        tick();
        @(negedge CLK);
        chk("single_rsp_rdy", 32'(rsp_rdy), 32'(4'b0001));
        chk("single_rsp_data", 32'(rsp_data), 32'(1));
        tick();

        // fairness between 1 and 3
        do_reset();
        gbase      = glog.size();
        rereq_mask = 4'b1010;
        y_allow    = 1'b1;
        take_mask  = '1;
        repeat (14) tick();
        rereq_mask = '0;
        repeat (6) tick();
        chk("fair_enough", 32'(glog.size() - gbase >= 6), 32'(1));
        for (int k = 0; k < 6; k++)
            if (gbase + k < glog.size()) chk("fair_grant", 32'(glog[gbase+k]), 32'((k % 2 == 0) ? 1 : 3));

        // backpressure on b
        do_reset();
        gbase     = glog.size();
        tbase     = take_log.size();
        y_allow   = 1'b1;
        take_mask = '1;
        or_b_rdy  = 1'b0;
        send(0, 1'b1, 1'b0);
        send(2, 1'b0, 1'b1);
        repeat (3) tick();
        @(negedge CLK);
        chk("bp_no_issue", 32'(or_a_en), 32'(0));
        chk("bp_slots_full", 32'(req_rdy), 32'(4'b1010));
        tick();
        or_b_rdy = 1'b1;
        repeat (6) tick();
        chk("bp_issues", 32'(glog.size() - gbase), 32'(2));
        if (glog.size() >= gbase + 2) begin
            chk("bp_g0", 32'(glog[gbase]), 32'(0));
            chk("bp_g1", 32'(glog[gbase+1]), 32'(2));
        end
        chk("bp_takes", 32'(take_log.size() - tbase), 32'(2));

        // FIFO full with responses stalled
        do_reset();
        gbase      = glog.size();
        rereq_mask = '1;
        repeat (10) tick();
        chk("full_issues", 32'(glog.size() - gbase), 32'(4));
        @(negedge CLK);
        chk("full_blocked", 32'(or_a_en), 32'(0));
        rereq_mask = '0;
        y_allow    = 1'b1;
        take_mask  = 4'b0001;
        tick();
        @(negedge CLK);
        chk("full_pop", 32'(or_y_en), 32'(1));
        chk("full_pop_no_issue", 32'(or_a_en), 32'(0));
        y_allow   = 1'b0;
        take_mask = '0;
        tick();
        @(negedge CLK);
        chk("full_refill_issue", 32'(or_a_en), 32'(1));
        tick();
        chk("full_issues_after", 32'(glog.size() - gbase), 32'(5));
        if (glog.size() >= gbase + 5) chk("full_g4", 32'(glog[gbase+4]), 32'(0));

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
